// File: rtl/mem_responder.sv
// Memory-side responder for the cpu's fetch and load/store bus ports.
// Both ports share one word-organised array. Each port has a one-deep pending
// slot. A single service FSM handles one access at a time, with LSU taking
// priority over IFU. Each response is a one-cycle respValid pulse issued a
// fixed LATENCY cycles after the request is accepted.
module mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        err_oob,
  output logic        err_proto
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_lsu_q, sel_lsu_d;
  logic       fire;

  // Pending slots
  logic        ifu_pend;
  logic [29:0] ifu_slot_addr;
  logic        lsu_pend;
  logic [31:0] lsu_slot_addr;
  logic [1:0]  lsu_slot_size;
  logic        lsu_slot_wen;
  logic [31:0] lsu_slot_wdata;
  logic [3:0]  lsu_slot_wmask;

  logic ifu_accept, ifu_dup;
  logic lsu_accept, lsu_dup;

  // Service datapath
  logic [31:0]      svc_addr;
  logic [31:0]      svc_off;
  logic             svc_ok;
  logic [IDX_W-1:0] svc_idx;
  logic [31:0]      rd_word;
  logic             svc_write;

  logic [31:0] mem [DEPTH_WORDS];

  // lsu_size is informational only; address low bits are not needed for word access
  logic unused_bits;
  assign unused_bits = ^{lsu_slot_size, ifu_addr[1:0], svc_off[1:0]};

  assign ifu_accept = ifu_reqValid & ~ifu_pend;
  assign ifu_dup    = ifu_reqValid &  ifu_pend;
  assign lsu_accept = lsu_reqValid & ~lsu_pend;
  assign lsu_dup    = lsu_reqValid &  lsu_pend;

  // Select the slot being serviced and decode its address against the array window
  always_comb begin
    svc_addr  = sel_lsu_q ? lsu_slot_addr : {ifu_slot_addr, 2'b00};
    svc_off   = svc_addr - ADDR_BASE;
    svc_ok    = (svc_addr >= ADDR_BASE) && ((svc_off >> 2) < DEPTH_WORDS);
    svc_idx   = svc_off[IDX_W+1:2];
    rd_word   = mem[svc_idx];
    svc_write = fire & sel_lsu_q & lsu_slot_wen & svc_ok;
  end

  // FSM next state. In IDLE, a request arriving this cycle is considered along
  // with already-latched slots, so the accept edge is also the service start edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_lsu_d = sel_lsu_q;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_pend || lsu_reqValid) begin
          state_d   = BUSY;
          cnt_d     = 4'(LATENCY - 1);
          sel_lsu_d = 1'b1;
        end else if (ifu_pend || ifu_reqValid) begin
          state_d   = BUSY;
          cnt_d     = 4'(LATENCY - 1);
          sel_lsu_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, countdown and serviced-port register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_lsu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_lsu_q <= sel_lsu_d;
    end
  end

  // Per-port pending slots: latch on a free slot, free on the response edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifu_pend       <= 1'b0;
      ifu_slot_addr  <= '0;
      lsu_pend       <= 1'b0;
      lsu_slot_addr  <= '0;
      lsu_slot_size  <= '0;
      lsu_slot_wen   <= 1'b0;
      lsu_slot_wdata <= '0;
      lsu_slot_wmask <= '0;
    end else begin
      if (fire && !sel_lsu_q) begin
        ifu_pend <= 1'b0;
      end else if (ifu_accept) begin
        ifu_pend      <= 1'b1;
        ifu_slot_addr <= ifu_addr[31:2];
      end
      if (fire && sel_lsu_q) begin
        lsu_pend <= 1'b0;
      end else if (lsu_accept) begin
        lsu_pend       <= 1'b1;
        lsu_slot_addr  <= lsu_addr;
        lsu_slot_size  <= lsu_size;
        lsu_slot_wen   <= lsu_wen;
        lsu_slot_wdata <= lsu_wdata;
        lsu_slot_wmask <= lsu_wmask;
      end
    end
  end

  // Byte-masked array write on the store's response edge
  always_ff @(posedge clock) begin
    if (svc_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lsu_slot_wmask[i]) begin
          mem[svc_idx][8*i +: 8] <= lsu_slot_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response pulses, held read data and sticky error flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifu_respValid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_respValid <= 1'b0;
      lsu_rdata     <= '0;
      err_oob       <= 1'b0;
      err_proto     <= 1'b0;
    end else begin
      ifu_respValid <= fire & ~sel_lsu_q;
      lsu_respValid <= fire &  sel_lsu_q;
      if (fire && !sel_lsu_q) begin
        ifu_rdata <= svc_ok ? rd_word : '0;
      end
      if (fire && sel_lsu_q) begin
        lsu_rdata <= (svc_ok && !lsu_slot_wen) ? rd_word : '0;
      end
      if (fire && !svc_ok) begin
        err_oob <= 1'b1;
      end
      if (ifu_dup || lsu_dup) begin
        err_proto <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed requests push expected responses into
// per-port queues, and a negedge monitor pops and checks them. Two extra
// instances with LATENCY=1 and LATENCY=4 cover the latency sweep and the
// mid-operation reset.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid, ifu_respValid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_reqValid, lsu_respValid, lsu_wen;
  logic [31:0] lsu_addr, lsu_rdata, lsu_wdata;
  logic [1:0]  lsu_size;
  logic [3:0]  lsu_wmask;
  logic        err_oob, err_proto;

  // Sweep instances share these inputs
  logic        s_lsu_reqValid, s_lsu_wen;
  logic [31:0] s_lsu_addr, s_lsu_wdata;
  logic [3:0]  s_lsu_wmask;
  logic        s_ifu_reqValid;
  logic [31:0] s_ifu_addr;
  logic        l1_ifu_v, l1_lsu_v, l1_oob, l1_proto;
  logic [31:0] l1_ifu_d, l1_lsu_d;
  logic        l4_ifu_v, l4_lsu_v, l4_oob, l4_proto;
  logic [31:0] l4_ifu_d, l4_lsu_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t ifu_q[$];
  exp_t lsu_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_responder #(.LATENCY(2)) u_dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .err_oob(err_oob), .err_proto(err_proto)
  );

  mem_responder #(.LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset),
    .ifu_reqValid(s_ifu_reqValid), .ifu_addr(s_ifu_addr),
    .ifu_respValid(l1_ifu_v), .ifu_rdata(l1_ifu_d),
    .lsu_reqValid(s_lsu_reqValid), .lsu_addr(s_lsu_addr), .lsu_size(2'd2),
    .lsu_wen(s_lsu_wen), .lsu_wdata(s_lsu_wdata), .lsu_wmask(s_lsu_wmask),
    .lsu_respValid(l1_lsu_v), .lsu_rdata(l1_lsu_d),
    .err_oob(l1_oob), .err_proto(l1_proto)
  );

  mem_responder #(.LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset),
    .ifu_reqValid(s_ifu_reqValid), .ifu_addr(s_ifu_addr),
    .ifu_respValid(l4_ifu_v), .ifu_rdata(l4_ifu_d),
    .lsu_reqValid(s_lsu_reqValid), .lsu_addr(s_lsu_addr), .lsu_size(2'd2),
    .lsu_wen(s_lsu_wen), .lsu_wdata(s_lsu_wdata), .lsu_wmask(s_lsu_wmask),
    .lsu_respValid(l4_lsu_v), .lsu_rdata(l4_lsu_d),
    .err_oob(l4_oob), .err_proto(l4_proto)
  );

  // Monitor: every response pulse must match the oldest expectation for its port
  always @(negedge clock) begin
    exp_t e;
    if (ifu_respValid) begin
      checks++;
      if (ifu_q.size() == 0) begin
        errors++;
        $display("FAIL ifu_unexpected cyc=%0d rdata=%h", cyc, ifu_rdata);
      end else begin
        e = ifu_q.pop_front();
        if (ifu_rdata !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL ifu_resp got data=%h cyc=%0d want data=%h cyc=%0d",
                   ifu_rdata, cyc, e.data, e.at);
        end
      end
    end
    if (lsu_respValid) begin
      checks++;
      if (lsu_q.size() == 0) begin
        errors++;
        $display("FAIL lsu_unexpected cyc=%0d rdata=%h", cyc, lsu_rdata);
      end else begin
        e = lsu_q.pop_front();
        if (lsu_rdata !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL lsu_resp got data=%h cyc=%0d want data=%h cyc=%0d",
                   lsu_rdata, cyc, e.data, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called at a negedge; the request is sampled at the following posedge
  task automatic ifu_issue(input logic [31:0] addr, input logic [31:0] exp_d, input int delay);
    ifu_reqValid = 1'b1;
    ifu_addr     = addr;
    ifu_q.push_back('{exp_d, cyc + 1 + delay});
  endtask

  task automatic lsu_issue(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [31:0] exp_d, input int delay);
    lsu_reqValid = 1'b1;
    lsu_addr     = addr;
    lsu_wen      = wen;
    lsu_wdata    = wdata;
    lsu_wmask    = wmask;
    lsu_size     = 2'd2;
    lsu_q.push_back('{exp_d, cyc + 1 + delay});
  endtask

  task automatic step();
    @(negedge clock);
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (ifu_q.size() != 0 || lsu_q.size() != 0); i++) @(negedge clock);
    checks++;
    if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got ifu_left=%0d lsu_left=%0d want 0 0", ifu_q.size(), lsu_q.size());
      ifu_q.delete();
      lsu_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    lsu_issue(addr, 1'b1, data, 4'hF, 32'h0, 2);
    step();
    drain();
  endtask

  // Watch both sweep instances for lim negedges, recording response position and data
  task automatic watch(input int lim, output int c1, output int c4, output int n1, output int n4,
                       output logic [31:0] d1, output logic [31:0] d4);
    c1 = 0; c4 = 0; n1 = 0; n4 = 0; d1 = '0; d4 = '0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clock);
      s_lsu_reqValid = 1'b0;
      if (l1_lsu_v) begin n1++; c1 = i; d1 = l1_lsu_d; end
      if (l4_lsu_v) begin n4++; c4 = i; d4 = l4_lsu_d; end
    end
  endtask

  task automatic s_issue(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
    s_lsu_reqValid = 1'b1;
    s_lsu_addr     = addr;
    s_lsu_wen      = wen;
    s_lsu_wdata    = wdata;
    s_lsu_wmask    = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int c1, c4, n1, n4;
    logic [31:0] d1, d4;
    reset = 1'b1;
    ifu_reqValid = 1'b0; ifu_addr = '0;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0;
    s_lsu_reqValid = 1'b0; s_lsu_addr = '0; s_lsu_wen = 1'b0; s_lsu_wdata = '0;
    s_lsu_wmask = '0; s_ifu_reqValid = 1'b0; s_ifu_addr = '0;
    repeat (3) @(negedge clock);
    check("rst_ifu_valid", ifu_respValid, 0);
    check("rst_lsu_valid", lsu_respValid, 0);
    check("rst_ifu_rdata", ifu_rdata, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    check("rst_errs", {err_oob, err_proto}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Preload through the store path
    store_word(32'h8000_0000, 32'h0000_0013);
    store_word(32'h8000_0104, 32'h1122_3344);
    store_word(32'h8000_0010, 32'hCAFE_F00D);
    store_word(32'h8000_3FFC, 32'hDEAD_BEEF);

    // Fetch with 2-cycle latency; data holds after the pulse
    ifu_issue(32'h8000_0000, 32'h0000_0013, 2);
    step();
    drain();
    repeat (3) @(negedge clock);
    check("ifu_rdata_hold", ifu_rdata, 32'h0000_0013);
    check("ifu_valid_low", ifu_respValid, 0);
    ifu_issue(32'h8000_0012, 32'hCAFE_F00D, 2);
    step();
    drain();

    // Byte store into lane 1, then read back
    lsu_issue(32'h8000_0104, 1'b1, 32'h0000_AB00, 4'b0010, 32'h0, 2);
    step();
    drain();
    lsu_issue(32'h8000_0104, 1'b0, 32'h0, 4'h0, 32'h1122_AB44, 2);
    step();
    drain();

    // Simultaneous requests: LSU at +2, IFU at +5
    lsu_issue(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 2);
    ifu_issue(32'h8000_0000, 32'h0000_0013, 5);
    step();
    drain();
    check("oob_clear", err_oob, 0);

    // Out-of-range load below base and store just past the top
    lsu_issue(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 32'h0, 2);
    step();
    drain();
    check("oob_set", err_oob, 1);
    lsu_issue(32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 2);
    step();
    drain();
    lsu_issue(32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2);
    step();
    drain();
    lsu_issue(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 2);
    step();
    drain();
    check("proto_clear", err_proto, 0);

    // Duplicate fetch while one is outstanding: one response only
    ifu_issue(32'h8000_0104, 32'h1122_AB44, 2);
    step();
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0000;
    step();
    drain();
    repeat (5) @(negedge clock);
    check("proto_set", err_proto, 1);

    // Reset one cycle after an LSU request: the response must never appear
    lsu_reqValid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0;
    step();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_mid_lsu_valid", lsu_respValid, 0);
    check("rst_mid_errs", {err_oob, err_proto}, 0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    lsu_issue(32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 2);
    step();
    drain();

    // Latency sweep: response expected on negedge number LATENCY+1 after issue
    s_issue(32'h8000_0020, 1'b1, 32'h5A5A_1234);
    watch(8, c1, c4, n1, n4, d1, d4);
    check("l1_store_lat", c1, 2);
    check("l4_store_lat", c4, 5);
    check("l1_store_cnt", n1, 1);
    check("l4_store_cnt", n4, 1);
    check("sw_store_rdata", d1 | d4, 0);
    s_issue(32'h8000_0020, 1'b0, 32'h0);
    watch(8, c1, c4, n1, n4, d1, d4);
    check("l1_load_lat", c1, 2);
    check("l4_load_lat", c4, 5);
    check("l1_load_data", d1, 32'h5A5A_1234);
    check("l4_load_data", d4, 32'h5A5A_1234);

    // Sweep reset mid-operation, then a fresh request
    s_issue(32'h8000_0020, 1'b0, 32'h0);
    @(negedge clock);
    s_lsu_reqValid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    watch(8, c1, c4, n1, n4, d1, d4);
    check("l1_after_rst_cnt", n1, 0);
    check("l4_after_rst_cnt", n4, 0);
    s_issue(32'h8000_0020, 1'b0, 32'h0);
    watch(8, c1, c4, n1, n4, d1, d4);
    check("l1_fresh_lat", c1, 2);
    check("l4_fresh_lat", c4, 5);
    check("l1_fresh_data", d1, 32'h5A5A_1234);
    check("l4_fresh_data", d4, 32'h5A5A_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
